// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Round-robin sharing of the main-memory port between ICache and
//               DCache; sequences line-burst beat addresses and word index.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LINE_WORDS = 8,
    localparam int IDX_W     = $clog2(LINE_WORDS),
    localparam int OFF_W     = IDX_W + 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,
    output logic [IDX_W-1:0]  i_idx,
    output logic              i_done,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic [IDX_W-1:0]  d_idx,
    output logic              d_done,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall_if,
    output logic              miss
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_BUSY_I = 3'd1,
        S_BUSY_D = 3'd2,
        S_DONE_I = 3'd3,
        S_DONE_D = 3'd4
    } state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        cnt_q, cnt_d;
    logic                    last_q, last_d;
    logic [ADDR_W-OFF_W-1:0] base_q, base_d;
    logic                    we_q, we_d;

    logic                    busy_i;
    logic                    busy_d;
    logic                    last_beat;
    logic                    unused_offset_bits;

    assign busy_i    = (state_q == S_BUSY_I);
    assign busy_d    = (state_q == S_BUSY_D);
    assign last_beat = (cnt_q == IDX_W'(LINE_WORDS - 1));

    // Line offsets of the request addresses are replaced by the beat counter.
    assign unused_offset_bits = ^{i_addr[OFF_W-1:0], d_addr[OFF_W-1:0]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        base_d  = base_q;
        we_d    = we_q;
        case (state_q)
            S_IDLE: begin
                // On contention the requester not served last wins.
                if (d_req && (!i_req || last_q)) begin
                    state_d = S_BUSY_D;
                    base_d  = d_addr[ADDR_W-1:OFF_W];
                    we_d    = d_we;
                    cnt_d   = '0;
                end else if (i_req) begin
                    state_d = S_BUSY_I;
                    base_d  = i_addr[ADDR_W-1:OFF_W];
                    we_d    = 1'b0;
                    cnt_d   = '0;
                end
            end
            S_BUSY_I: begin
                if (mem_ack) begin
                    cnt_d = cnt_q + 1'b1;
                    if (last_beat) begin
                        state_d = S_DONE_I;
                        last_d  = 1'b1;
                    end
                end
            end
            S_BUSY_D: begin
                if (mem_ack) begin
                    cnt_d = cnt_q + 1'b1;
                    if (last_beat) begin
                        state_d = S_DONE_D;
                        last_d  = 1'b0;
                    end
                end
            end
            S_DONE_I, S_DONE_D: state_d = S_IDLE;
            default:            state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            last_q  <= 1'b1;
            base_q  <= '0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            base_q  <= base_d;
            we_q    <= we_d;
        end
    end

    assign mem_req   = busy_i | busy_d;
    assign mem_we    = busy_d & we_q;
    assign mem_addr  = mem_req ? {base_q, cnt_q, 2'b00} : '0;
    assign mem_wdata = mem_req ? d_wdata : '0;

    assign i_rvalid  = busy_i & mem_ack & ~we_q;
    assign i_rdata   = busy_i ? mem_rdata : '0;
    assign i_idx     = busy_i ? cnt_q : '0;
    assign i_done    = (state_q == S_DONE_I);

    assign d_rvalid  = busy_d & mem_ack & ~we_q;
    assign d_rdata   = busy_d ? mem_rdata : '0;
    assign d_idx     = busy_d ? cnt_q : '0;
    assign d_done    = (state_q == S_DONE_D);

    assign stall_if  = i_req & ~i_done;
    assign miss      = d_req & ~d_done;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Directed scoreboard bench for mem_port_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int          LW     = 8;
    localparam logic [31:0] RD_KEY = 32'h5A5A_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, d_req, d_we, mem_ack;
    logic [31:0] i_addr, d_addr, d_wdata, mem_rdata;
    logic        i_rvalid, i_done, d_rvalid, d_done;
    logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
    logic [2:0]  i_idx, d_idx;
    logic        mem_req, mem_we, stall_if, miss;

    typedef struct {
        bit          port;   // 0 = ICache, 1 = DCache
        logic [31:0] addr;
        bit          we;
        int          idx;
    } beat_t;

    beat_t sb[$];
    beat_t exp_b;
    beat_t last_pop;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc = 0, req_run = 0, burst_len = 0, first_beat_cyc = 0, last_ack_cyc = 0;
    int ack_period = 1;
    bit spur_ack = 1'b0;
    bit got_i_done, got_d_done;
    int req_cyc, dd_cyc;

    always #5 clk = ~clk;

    assign d_wdata   = 32'hA0 + 32'(d_idx);
    assign mem_rdata = mem_addr ^ RD_KEY;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .LINE_WORDS(LW)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .i_idx(i_idx), .i_done(i_done),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_idx(d_idx), .d_done(d_done),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .stall_if(stall_if), .miss(miss)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_line(input bit port, input logic [31:0] addr, input bit we);
        for (int i = 0; i < LW; i++) begin
            beat_t b;
            b.port = port;
            b.addr = {addr[31:5], 5'b0} + 32'(i * 4);
            b.we   = we;
            b.idx  = i;
            sb.push_back(b);
        end
    endtask

    // One clock cycle: memory model drives ack at the falling edge, outputs
    // are compared 1 ns later against the head of the scoreboard.
    task automatic step();
        @(negedge clk);
        cyc++;
        got_i_done = 1'b0;
        got_d_done = 1'b0;
        if (mem_req) begin
            if (req_run == 0) first_beat_cyc = cyc;
            req_run++;
        end else begin
            if (req_run != 0) burst_len = req_run;
            req_run = 0;
        end
        mem_ack = spur_ack || (mem_req && (req_run % ack_period == 0));
        #1;
        if (mem_req) begin
            check("sb_has_beat", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                exp_b = sb[0];
                check("mem_addr", mem_addr, exp_b.addr);
                check("mem_we", mem_we, exp_b.we);
                check("i_idx", i_idx, exp_b.port ? 64'd0 : 64'(exp_b.idx));
                check("d_idx", d_idx, exp_b.port ? 64'(exp_b.idx) : 64'd0);
                check("i_rvalid", i_rvalid, mem_ack && !exp_b.port);
                check("d_rvalid", d_rvalid, mem_ack && exp_b.port && !exp_b.we);
                if (exp_b.port) check("miss_busy", miss, 1);
                else            check("stall_if_busy", stall_if, 1);
                if (mem_ack) begin
                    if (exp_b.we)        check("mem_wdata", mem_wdata, 32'hA0 + 32'(exp_b.idx));
                    else if (exp_b.port) check("d_rdata", d_rdata, exp_b.addr ^ RD_KEY);
                    else                 check("i_rdata", i_rdata, exp_b.addr ^ RD_KEY);
                    last_pop     = sb.pop_front();
                    last_ack_cyc = cyc;
                end
            end
        end else begin
            check("i_rvalid_idle", i_rvalid, 0);
            check("d_rvalid_idle", d_rvalid, 0);
        end
        if (i_done) begin
            got_i_done = 1'b1;
            check("stall_if_done", stall_if, 0);
            check("i_done_after_ack", 64'(last_ack_cyc), 64'(cyc - 1));
            check("i_done_last_beat", 64'({last_pop.port, 3'(last_pop.idx)}), 64'(LW - 1));
            i_req = 1'b0;
        end
        if (d_done) begin
            got_d_done = 1'b1;
            check("miss_done", miss, 0);
            check("d_done_after_ack", 64'(last_ack_cyc), 64'(cyc - 1));
            check("d_done_last_beat", 64'({last_pop.port, 3'(last_pop.idx)}), 64'(8 + LW - 1));
            d_req = 1'b0;
        end
    endtask

    task automatic wait_done(input bit port, input int budget, input string tag);
        int n = 0;
        do begin
            step();
            n++;
        end while (!(port ? got_d_done : got_i_done) && n < budget);
        check(tag, port ? got_d_done : got_i_done, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; mem_ack = 1'b0;
        i_addr = '0; d_addr = '0;

        // Reset values.
        step(); step();
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_i_done", i_done, 0);
        check("rst_d_done", d_done, 0);
        check("rst_stall_if", stall_if, 0);
        d_req = 1'b1; #1;
        check("rst_miss_follows_req", miss, 1);
        d_req = 1'b0;
        step();
        rst = 1'b1;

        // Both requesters in the first cycle after reset: DCache first.
        i_req = 1'b1; i_addr = 32'h0000_0104;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_2000;
        req_cyc = cyc;
        #1;
        check("miss_same_cycle", miss, 1);
        check("stall_same_cycle", stall_if, 1);
        push_line(1'b1, 32'h2000, 1'b0);
        push_line(1'b0, 32'h0104, 1'b0);
        wait_done(1'b1, 40, "both_d_done_seen");
        dd_cyc = cyc;
        check("d_first_beat_lat", 64'(first_beat_cyc), 64'(req_cyc + 1));
        check("d_done_latency", 64'(dd_cyc), 64'(req_cyc + LW + 1));
        step();
        check("idle_after_done", mem_req, 0);
        check("burst_len_fast", 64'(burst_len), 64'(LW));
        wait_done(1'b0, 40, "both_i_done_seen");
        check("i_first_beat_after_d", 64'(first_beat_cyc), 64'(dd_cyc + 2));

        // Round robin: DCache served, then both pending -> ICache next.
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_4000;
        push_line(1'b1, 32'h4000, 1'b0);
        wait_done(1'b1, 40, "rr_d_alone_done");
        i_req = 1'b1; i_addr = 32'h0000_0500;
        d_req = 1'b1; d_addr = 32'h0000_4100;
        push_line(1'b0, 32'h0500, 1'b0);
        push_line(1'b1, 32'h4100, 1'b0);
        wait_done(1'b0, 40, "rr_i_done");
        wait_done(1'b1, 40, "rr_d_done");

        // Writeback.
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_3000;
        push_line(1'b1, 32'h3000, 1'b1);
        wait_done(1'b1, 40, "wb_done");
        d_we = 1'b0;
        step();

        // Spurious ack in IDLE, then a burst with ack every third cycle.
        spur_ack = 1'b1;
        step();
        spur_ack = 1'b0;
        step();
        check("spur_no_req", mem_req, 0);
        check("spur_i_idx", i_idx, 0);
        check("spur_d_idx", d_idx, 0);
        ack_period = 3;
        i_req = 1'b1; i_addr = 32'h0000_0600;
        push_line(1'b0, 32'h0600, 1'b0);
        wait_done(1'b0, 60, "slow_i_done");
        step();
        check("burst_len_slow", 64'(burst_len), 64'(3 * LW));
        ack_period = 1;

        // Reset in the middle of a DCache read.
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_7000;
        push_line(1'b1, 32'h7000, 1'b0);
        for (int n = 0; n < 20 && sb.size() > LW - 3; n++) step();
        check("mid_acks_taken", 64'(sb.size()), 64'(LW - 3));
        rst = 1'b0;
        #1;
        check("abort_mem_req", mem_req, 0);
        check("abort_d_done", d_done, 0);
        check("abort_d_rvalid", d_rvalid, 0);
        check("abort_mem_addr", mem_addr, 0);
        check("abort_miss", miss, 1);
        sb.delete();
        d_req = 1'b0;
        step();
        rst = 1'b1;
        step();
        d_req = 1'b1;
        push_line(1'b1, 32'h7000, 1'b0);
        wait_done(1'b1, 40, "restart_d_done");
        step();

        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single main-memory port between the instruction cache and the data cache of the 5-stage pipeline. Each cache line fill or writeback is one transaction: a burst of LINE_WORDS word beats. The block arbitrates between the two caches with round-robin priority and sequences the beat addresses and the word counter. It also produces the IF stall and the data-miss signal (`miss`) that feed the hazard unit.

## Interface
- ADDR_W, 32, byte address width
- DATA_W, 32, word width
- LINE_WORDS, 8, words per cache line (power of 2, ≥2)
- OFF_W, log2(LINE_WORDS)+2, line offset bits (derived)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- i_req  in  1  ICache refill request; held until i_done
- i_addr  in  ADDR_W  ICache line address; offset bits ignored
- i_rvalid  out  1  refill word valid this cycle
- i_rdata  out  DATA_W  refill word
- i_idx  out  log2(LINE_WORDS)  index of current word
- i_done  out  1  one-cycle pulse: transaction complete
- d_req  in  1  DCache request; held until d_done
- d_we  in  1  1 = writeback, 0 = refill; stable while d_req
- d_addr  in  ADDR_W  DCache line address
- d_wdata  in  DATA_W  writeback word for index d_idx (combinational from the cache)
- d_rvalid, d_rdata, d_idx, d_done  out  as the i_* equivalents
- mem_req  out  1  beat request to main memory
- mem_we  out  1  beat is a write
- mem_addr  out  ADDR_W  beat word address
- mem_wdata  out  DATA_W  beat write data
- mem_ack  in  1  beat complete; read data valid in the same cycle
- mem_rdata  in  DATA_W  read data
- stall_if  out  1  i_req & ~i_done
- miss  out  1  d_req & ~d_done (to the hazard unit)

## Operation
- States: IDLE, BUSY_I, BUSY_D, DONE_I, DONE_D.
- Registers:
  - `last` (1 = ICache served last), reset 1.
  - `cnt` (log2(LINE_WORDS) bits).
  - Latched `base` = addr[ADDR_W-1:OFF_W].
  - Latched `we`.
- IDLE:
  - Only d_req: go to BUSY_D.
  - Only i_req: go to BUSY_I.
  - Both: grant the requester not served last. After reset this means DCache first.
  - On grant, latch base and we, and clear cnt.
- BUSY_x:
  - Drive mem_req=1, mem_addr={base, cnt, 2'b00}, mem_we=we (always 0 for I), mem_wdata=d_wdata.
  - On mem_ack: cnt+1. On the ack with cnt==LINE_WORDS-1, go to DONE_x and set last accordingly.
- DONE_x:
  - mem_req=0 and x_done=1 for exactly one cycle, then IDLE.
  - The requester must drop req in the cycle after done. Because DONE_x always passes through IDLE, a stale request is never re-granted.
- Outputs:
  - x_rvalid = BUSY_x & mem_ack & ~we.
  - x_rdata = mem_rdata.
  - x_idx = cnt while BUSY_x, otherwise 0.
- mem_ack outside the BUSY states is ignored.
- Inputs i_addr and d_addr are sampled only at grant; later changes have no effect.
- Reset (asynchronous, any state, including mid-burst):
  - State IDLE, cnt=0, last=1, base=0, we=0.
  - All outputs 0, except that stall_if and miss follow the combinational request terms.
  - An aborted burst is not resumed; the next grant restarts at word 0.

## Timing
- Request seen in IDLE at edge t: mem_req=1 from cycle t+1.
- With mem_ack every cycle, a transaction occupies LINE_WORDS cycles of mem_req plus 1 DONE cycle plus 1 IDLE cycle. The pending requester's first beat comes at DONE+2.
- Latency from req to done = LINE_WORDS+1 cycles minimum. Each ack stall cycle adds one cycle.
- miss and stall_if are combinational: high in the same cycle req rises, low in the done cycle.
- No combinational path from mem_ack to mem_req.

## Test plan
- i_req, i_addr=0x104, ack every cycle:
  - mem_addr 0x100,0x104,…,0x11C on 8 consecutive cycles.
  - i_rvalid on each, with i_idx 0..7.
  - i_done in the cycle after the last ack.
  - stall_if low in the done cycle.
- i_req and d_req (read, 0x2000) both asserted in the first cycle after reset:
  - DCache burst first (0x2000..0x201C), with miss high throughout.
  - d_done, then IDLE, then the ICache burst begins.
- d_req served, then i_req and d_req both pending: ICache granted next (round robin), then DCache.
- d_we=1, d_addr=0x3000, bench returns d_wdata=0xA0+d_idx:
  - mem_we=1 on all 8 beats.
  - mem_wdata 0xA0..0xA7 at 0x3000..0x301C.
  - d_rvalid never asserted.
- mem_ack on every 3rd cycle, plus a spurious ack in IDLE:
  - cnt advances only on acks.
  - The burst takes 24 cycles.
  - The spurious ack causes no state change.
- rst low after 3 acks of a DCache read:
  - mem_req=0, d_done=0 immediately.
  - After release, a re-issued d_req restarts at word 0 with base address.
